// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS pipeline.
// Define IF_STALL_CNT_EN to add the saturating stall_cnt output.

module if_stage_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_rst,
    input  logic        if_en,
    input  logic        id_rst,
    input  logic        id_en,
    input  logic [2:0]  pc_src,
    input  logic [31:0] fwd_rs_data,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        if_valid,
    output logic [31:0] inst_id,
    output logic [31:0] pc_id,
    output logic        id_valid,
    output logic        fetch_stall
`ifdef IF_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_t;

    localparam logic [31:0] PC_START   = {PC_RESET[31:2], 2'b00};
    localparam logic [2:0]  SRC_JUMP   = 3'd1;
    localparam logic [2:0]  SRC_FWD    = 3'd2;
    localparam logic [2:0]  SRC_BRANCH = 3'd3;

    state_t      state;
    state_t      state_nxt;
    state_t      abort_state;
    logic [31:0] pc_if;
    logic [31:0] pc_if_nxt;
    logic [31:0] buf_inst;
    logic [31:0] buf_inst_nxt;
    logic [31:0] drop_addr;
    logic [31:0] drop_addr_nxt;
    logic [31:0] inst_id_nxt;
    logic [31:0] pc_id_nxt;
    logic        id_valid_nxt;

    logic        have_inst;
    logic [31:0] cur_inst;
    logic        redirect;
    logic        take_redirect;
    logic        take_handoff;
    logic [31:0] target;
    logic [31:0] branch_off;

    assign have_inst   = ((state == S_REQ) && imem_ack) || (state == S_HOLD);
    assign cur_inst    = (state == S_HOLD) ? buf_inst : imem_data;
    assign if_valid    = have_inst;
    assign fetch_stall = !have_inst;

    // A stale request keeps its original address on the bus until it is acked.
    assign imem_req  = (state != S_HOLD);
    assign imem_addr = (state == S_DROP) ? drop_addr : pc_if;

    assign redirect = id_valid && id_en &&
                      ((pc_src == SRC_JUMP) || (pc_src == SRC_FWD) || (pc_src == SRC_BRANCH));

    // Stage resets outrank redirects, which in turn outrank the normal handoff.
    assign take_redirect = redirect && !if_rst && !id_rst;
    assign take_handoff  = if_en && id_en && have_inst && !redirect && !if_rst && !id_rst;

    assign branch_off = {{14{inst_id[15]}}, inst_id[15:0], 2'b00};

    always_comb begin
        target = pc_id + 32'd4;
        case (pc_src)
            SRC_JUMP:   target = {pc_id[31:28], inst_id[25:0], 2'b00};
            SRC_FWD:    target = fwd_rs_data;
            SRC_BRANCH: target = pc_id + 32'd4 + branch_off;
            default:    target = pc_id + 32'd4;
        endcase
    end

    // Leaving a request that has not been acked must swallow its late ack.
    assign abort_state = ((state != S_HOLD) && !imem_ack) ? S_DROP : S_REQ;

    always_comb begin
        state_nxt     = state;
        pc_if_nxt     = pc_if;
        buf_inst_nxt  = buf_inst;
        drop_addr_nxt = drop_addr;

        if (if_rst || take_redirect) begin
            pc_if_nxt    = if_rst ? PC_START : (target & ~32'h3);
            buf_inst_nxt = '0;
            state_nxt    = abort_state;
            if (abort_state == S_DROP) begin
                drop_addr_nxt = imem_addr;
            end
        end else if (take_handoff) begin
            pc_if_nxt    = pc_if + 32'd4;
            buf_inst_nxt = '0;
            state_nxt    = S_REQ;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_ack) begin
                        buf_inst_nxt = imem_data;
                        state_nxt    = S_HOLD;
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        state_nxt = S_REQ;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    always_comb begin
        inst_id_nxt  = inst_id;
        pc_id_nxt    = pc_id;
        id_valid_nxt = id_valid;

        if (id_rst || take_redirect) begin
            inst_id_nxt  = NOP_INST;
            pc_id_nxt    = '0;
            id_valid_nxt = 1'b0;
        end else if (id_en) begin
            if (take_handoff) begin
                inst_id_nxt  = cur_inst;
                pc_id_nxt    = pc_if;
                id_valid_nxt = 1'b1;
            end else begin
                inst_id_nxt  = NOP_INST;
                pc_id_nxt    = '0;
                id_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_REQ;
            pc_if     <= PC_START;
            buf_inst  <= '0;
            drop_addr <= '0;
            inst_id   <= NOP_INST;
            pc_id     <= '0;
            id_valid  <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc_if     <= pc_if_nxt;
            buf_inst  <= buf_inst_nxt;
            drop_addr <= drop_addr_nxt;
            inst_id   <= inst_id_nxt;
            pc_id     <= pc_id_nxt;
            id_valid  <= id_valid_nxt;
        end
    end

`ifdef IF_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (if_rst) begin
            stall_cnt <= '0;
        end else if (fetch_stall && id_en && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/if_stage_fetch.md
Name: if_stage_fetch

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Owns the PC, drives a req/ack instruction-memory port, and applies redirects from the ID-stage pc_src decode.
- Delivers inst_id/pc_id/id_valid to the ID-stage decoder/controller and obeys its if_en/if_rst/id_en/id_rst pipeline controls.

Parameters:
- PC_RESET, 32'h0000_0000, PC value after reset or if_rst.
- NOP_INST, 32'h0000_0000, instruction placed in IF/ID on bubble or flush.

Ports:
- clk  in  1  main clock
- rst_n  in  1  asynchronous active-low reset
- if_rst, if_en, id_rst, id_en  in  1 each  stage reset/enable from controller
- pc_src  in  3  redirect select for the ID-stage instruction: 0 NEXT, 1 JUMP, 2 FWD_DATA (jr), 3 BRANCH; others are treated as NEXT
- fwd_rs_data  in  32  forwarded rs value, the jr target
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, word-aligned
- imem_ack  in  1  fetch done; imem_data valid this cycle
- imem_data  in  32  fetched instruction
- if_valid  out  1  IF holds a deliverable instruction this cycle
- inst_id  out  32  IF/ID instruction
- pc_id  out  32  IF/ID PC
- id_valid  out  1  IF/ID valid
- fetch_stall  out  1  IF has nothing to deliver

Behaviour:
- Reset (rst_n=0, async):
  - pc_if=PC_RESET, FSM=S_REQ.
  - inst_id=NOP_INST, pc_id=0, id_valid=0.
  - The instruction buffer is cleared.
- FSM states:
  - S_REQ: imem_req=1, imem_addr=pc_if. Zero-wait ack (same cycle) is legal. Address is held stable until ack.
  - S_HOLD: an instruction is buffered and waiting for handoff; imem_req=0.
  - S_DROP: a stale request is outstanding; imem_req=1 with the old address; the ack is discarded.
- have_inst = (S_REQ && imem_ack) || S_HOLD. if_valid = have_inst. fetch_stall = !have_inst.
- Handoff = if_en && id_en && have_inst && !redirect.
- redirect = id_valid && id_en && pc_src in {1,2,3}.
- Targets:
  - JUMP = {pc_id[31:28], inst_id[25:0], 2'b00}.
  - BRANCH = pc_id + 4 + (sext(inst_id[15:0]) << 2).
  - FWD_DATA = fwd_rs_data.
  - All arithmetic is 32-bit and wraps modulo 2^32.
- Priority per cycle: rst_n > if_rst/id_rst > redirect > handoff > hold.
- if_rst:
  - pc_if <= PC_RESET.
  - FSM -> S_DROP if S_REQ && !imem_ack, else S_REQ.
  - Buffer is cleared.
- id_rst: IF/ID <= {NOP_INST, 0, valid=0}. Independent of if_rst.
- Redirect:
  - pc_if <= target.
  - IF/ID <= bubble (no delay slot; the wrong-path fetch is squashed).
  - FSM -> S_DROP if S_REQ && !imem_ack, else S_REQ.
  - Buffer is cleared.
- Handoff: IF/ID <= {inst, pc_if, 1}; pc_if <= pc_if+4; FSM -> S_REQ.
- Ack without handoff and without redirect (stall): capture into buffer, FSM -> S_HOLD, pc_if unchanged.
- id_en=1 with no instruction: IF/ID <= bubble.
- id_en=0: IF/ID holds its value.
- S_DROP + imem_ack: FSM -> S_REQ next cycle, using the current pc_if.
- A redirect while in S_DROP only updates pc_if; the FSM stays in S_DROP.
- pc_if[1:0] is always 0. imem_addr[1:0] = 0.

Optional Feature:
- Macro IF_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt[31:0], cleared by rst_n or if_rst.
  - Increments each cycle fetch_stall=1 && id_en=1, saturating at 32'hFFFF_FFFF.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Zero-wait memory (ack tied to req), 0x00: lw, 0x04: add, 0x08: ori -> pc_id 0,4,8 on consecutive cycles; id_valid=1 from the 2nd cycle after rst_n rises.
- ack delayed 2 cycles -> fetch_stall=1 for 2 cycles; ID receives 2 bubbles (id_valid=0); imem_addr stable throughout.
- beq at pc_id=0x10, imm=0x0003, pc_src=3 -> next imem_addr=0x20; slot after the beq is a bubble; next valid pc_id=0x20.
- j with target field 0x0000040 at 0x100 while a fetch of 0x104 is outstanding -> S_DROP; ack for 0x104 discarded; next request to 0x100; 0x104 never reaches ID.
- if_en=id_en=0 for 3 cycles as the fetch of 0x8 acks -> S_HOLD, imem_req=0; on re-enable pc_id=0x8 with no new request; then imem_addr=0xC.
- rst_n pulsed low mid-fetch with pc_if=0x40 -> immediately pc_if=PC_RESET, id_valid=0, inst_id=0. With IF_STALL_CNT_EN, stall_cnt=0; it counts 2 for the 2-cycle delayed-ack case above.
